// File: rtl/rv32i_encode.sv
// RV32I instruction encoder: turns a symbolic command into a 32-bit machine word.
// Define RV32I_ENCODE_LI_EXPAND_EN to enable the LI pseudo-op expansion (LUI + ADDI).
`timescale 1ns/1ps

module rv32i_encode #(
    parameter int unsigned N_param = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [4:0]         cmd_op_i,
    input  logic [4:0]         cmd_rd_i,
    input  logic [4:0]         cmd_rs1_i,
    input  logic [4:0]         cmd_rs2_i,
    input  logic [31:0]        cmd_imm_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [N_param-1:0] inst_word_o,
    output logic               inst_last_o,
    output logic               err_o
);

    localparam logic [4:0] OpAdd    = 5'd0;
    localparam logic [4:0] OpSub    = 5'd1;
    localparam logic [4:0] OpSll    = 5'd2;
    localparam logic [4:0] OpSlt    = 5'd3;
    localparam logic [4:0] OpSltu   = 5'd4;
    localparam logic [4:0] OpXor    = 5'd5;
    localparam logic [4:0] OpSrl    = 5'd6;
    localparam logic [4:0] OpSra    = 5'd7;
    localparam logic [4:0] OpOr     = 5'd8;
    localparam logic [4:0] OpAnd    = 5'd9;
    localparam logic [4:0] OpAddi   = 5'd10;
    localparam logic [4:0] OpSlti   = 5'd11;
    localparam logic [4:0] OpSltiu  = 5'd12;
    localparam logic [4:0] OpXori   = 5'd13;
    localparam logic [4:0] OpOri    = 5'd14;
    localparam logic [4:0] OpAndi   = 5'd15;
    localparam logic [4:0] OpSlli   = 5'd16;
    localparam logic [4:0] OpSrli   = 5'd17;
    localparam logic [4:0] OpSrai   = 5'd18;
    localparam logic [4:0] OpLw     = 5'd19;
    localparam logic [4:0] OpSw     = 5'd20;
    localparam logic [4:0] OpBeq    = 5'd21;
    localparam logic [4:0] OpBne    = 5'd22;
    localparam logic [4:0] OpJal    = 5'd23;
    localparam logic [4:0] OpJalr   = 5'd24;
    localparam logic [4:0] OpLui    = 5'd25;
    localparam logic [4:0] OpAuipc  = 5'd26;
    localparam logic [4:0] OpLi     = 5'd27;
    localparam logic [4:0] OpNop    = 5'd28;
    localparam logic [4:0] OpEcall  = 5'd29;
    localparam logic [4:0] OpEbreak = 5'd30;
    localparam logic [4:0] OpMret   = 5'd31;

    localparam logic [6:0] OpcOp     = 7'h33;
    localparam logic [6:0] OpcOpImm  = 7'h13;
    localparam logic [6:0] OpcLoad   = 7'h03;
    localparam logic [6:0] OpcStore  = 7'h23;
    localparam logic [6:0] OpcBranch = 7'h63;
    localparam logic [6:0] OpcJal    = 7'h6F;
    localparam logic [6:0] OpcJalr   = 7'h67;
    localparam logic [6:0] OpcLui    = 7'h37;
    localparam logic [6:0] OpcAuipc  = 7'h17;

    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm;
    logic        w_imm_i_ok;
    logic        w_shamt_ok;
    logic        w_imm_b_ok;
    logic        w_imm_j_ok;
    logic [31:0] w_enc_word;
    logic        w_enc_ok;
    logic        w_accept;
    logic        w_xfer;
    logic        w_idle;

    logic        r_valid;
    logic [31:0] r_word;
    logic        r_err;
    logic        w_valid_next;
    logic [31:0] w_word_next;
    logic        w_err_next;

    assign w_rd  = cmd_rd_i;
    assign w_rs1 = cmd_rs1_i;
    assign w_rs2 = cmd_rs2_i;
    assign w_imm = cmd_imm_i;

    // Range checks are sign-extension checks on the upper immediate bits.
    assign w_imm_i_ok = (w_imm[31:11] == {21{w_imm[11]}});
    assign w_shamt_ok = (w_imm[31:5] == 27'd0);
    assign w_imm_b_ok = (w_imm[31:12] == {20{w_imm[12]}}) && !w_imm[0];
    assign w_imm_j_ok = (w_imm[31:20] == {12{w_imm[20]}}) && !w_imm[0];

`ifdef RV32I_ENCODE_LI_EXPAND_EN
    typedef enum logic [0:0] {StIdle = 1'b0, StEmit2 = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last;
    logic        w_last_next;
    logic [31:0] r_word2;
    logic [31:0] w_word2_next;
    logic [31:0] w_word2;
    logic        w_enc_two;
    logic [19:0] w_li_hi;

    // Rounds the upper part so the sign-extended ADDI low part lands on the target value.
    assign w_li_hi     = w_imm[31:12] + {19'd0, w_imm[11]};
    assign w_idle      = (r_state == StIdle);
    assign inst_last_o = r_last;
`else
    assign w_idle      = 1'b1;
    assign inst_last_o = 1'b1;
`endif

    always_comb begin
        w_enc_word = {12'd0, 5'd0, 3'd0, 5'd0, OpcOpImm};
        w_enc_ok   = 1'b1;
`ifdef RV32I_ENCODE_LI_EXPAND_EN
        w_enc_two  = 1'b0;
        w_word2    = 32'd0;
`endif
        case (cmd_op_i)
            OpAdd:   w_enc_word = {7'h00, w_rs2, w_rs1, 3'd0, w_rd, OpcOp};
            OpSub:   w_enc_word = {7'h20, w_rs2, w_rs1, 3'd0, w_rd, OpcOp};
            OpSll:   w_enc_word = {7'h00, w_rs2, w_rs1, 3'd1, w_rd, OpcOp};
            OpSlt:   w_enc_word = {7'h00, w_rs2, w_rs1, 3'd2, w_rd, OpcOp};
            OpSltu:  w_enc_word = {7'h00, w_rs2, w_rs1, 3'd3, w_rd, OpcOp};
            OpXor:   w_enc_word = {7'h00, w_rs2, w_rs1, 3'd4, w_rd, OpcOp};
            OpSrl:   w_enc_word = {7'h00, w_rs2, w_rs1, 3'd5, w_rd, OpcOp};
            OpSra:   w_enc_word = {7'h20, w_rs2, w_rs1, 3'd5, w_rd, OpcOp};
            OpOr:    w_enc_word = {7'h00, w_rs2, w_rs1, 3'd6, w_rd, OpcOp};
            OpAnd:   w_enc_word = {7'h00, w_rs2, w_rs1, 3'd7, w_rd, OpcOp};
            OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi: begin
                w_enc_ok = w_imm_i_ok;
                case (cmd_op_i)
                    OpAddi:  w_enc_word = {w_imm[11:0], w_rs1, 3'd0, w_rd, OpcOpImm};
                    OpSlti:  w_enc_word = {w_imm[11:0], w_rs1, 3'd2, w_rd, OpcOpImm};
                    OpSltiu: w_enc_word = {w_imm[11:0], w_rs1, 3'd3, w_rd, OpcOpImm};
                    OpXori:  w_enc_word = {w_imm[11:0], w_rs1, 3'd4, w_rd, OpcOpImm};
                    OpOri:   w_enc_word = {w_imm[11:0], w_rs1, 3'd6, w_rd, OpcOpImm};
                    default: w_enc_word = {w_imm[11:0], w_rs1, 3'd7, w_rd, OpcOpImm};
                endcase
            end
            OpSlli: begin
                w_enc_ok   = w_shamt_ok;
                w_enc_word = {7'h00, w_imm[4:0], w_rs1, 3'd1, w_rd, OpcOpImm};
            end
            OpSrli: begin
                w_enc_ok   = w_shamt_ok;
                w_enc_word = {7'h00, w_imm[4:0], w_rs1, 3'd5, w_rd, OpcOpImm};
            end
            OpSrai: begin
                w_enc_ok   = w_shamt_ok;
                w_enc_word = {7'h20, w_imm[4:0], w_rs1, 3'd5, w_rd, OpcOpImm};
            end
            OpLw: begin
                w_enc_ok   = w_imm_i_ok;
                w_enc_word = {w_imm[11:0], w_rs1, 3'd2, w_rd, OpcLoad};
            end
            OpSw: begin
                w_enc_ok   = w_imm_i_ok;
                w_enc_word = {w_imm[11:5], w_rs2, w_rs1, 3'd2, w_imm[4:0], OpcStore};
            end
            OpBeq, OpBne: begin
                w_enc_ok   = w_imm_b_ok;
                w_enc_word = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 2'b00,
                              (cmd_op_i == OpBne), w_imm[4:1], w_imm[11], OpcBranch};
            end
            OpJal: begin
                w_enc_ok   = w_imm_j_ok;
                w_enc_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], w_rd, OpcJal};
            end
            OpJalr: begin
                w_enc_ok   = w_imm_i_ok;
                w_enc_word = {w_imm[11:0], w_rs1, 3'd0, w_rd, OpcJalr};
            end
            OpLui:    w_enc_word = {w_imm[19:0], w_rd, OpcLui};
            OpAuipc:  w_enc_word = {w_imm[19:0], w_rd, OpcAuipc};
            OpLi: begin
`ifdef RV32I_ENCODE_LI_EXPAND_EN
                if (w_imm_i_ok) begin
                    w_enc_word = {w_imm[11:0], 5'd0, 3'd0, w_rd, OpcOpImm};
                end else begin
                    w_enc_word = {w_li_hi, w_rd, OpcLui};
                    w_enc_two  = (w_imm[11:0] != 12'd0);
                    w_word2    = {w_imm[11:0], w_rd, 3'd0, w_rd, OpcOpImm};
                end
`else
                w_enc_ok = 1'b0;
`endif
            end
            OpNop:    w_enc_word = 32'h0000_0013;
            OpEcall:  w_enc_word = 32'h0000_0073;
            OpEbreak: w_enc_word = 32'h0010_0073;
            OpMret:   w_enc_word = 32'h3020_0073;
            default:  w_enc_ok   = 1'b0;
        endcase
    end

    assign cmd_ready_o = w_idle && (!r_valid || inst_ready_i);
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_xfer      = r_valid && inst_ready_i;

    always_comb begin
        w_valid_next = r_valid;
        w_word_next  = r_word;
        w_err_next   = 1'b0;
`ifdef RV32I_ENCODE_LI_EXPAND_EN
        w_state_next = r_state;
        w_last_next  = r_last;
        w_word2_next = r_word2;
`endif
        if (w_xfer) begin
            w_valid_next = 1'b0;
        end
        if (w_accept) begin
            if (w_enc_ok) begin
                w_valid_next = 1'b1;
                w_word_next  = w_enc_word;
`ifdef RV32I_ENCODE_LI_EXPAND_EN
                w_last_next  = !w_enc_two;
                if (w_enc_two) begin
                    w_state_next = StEmit2;
                    w_word2_next = w_word2;
                end
`endif
            end else begin
                w_err_next = 1'b1;
            end
        end
`ifdef RV32I_ENCODE_LI_EXPAND_EN
        // Second LI word loads in the same cycle the LUI word leaves.
        if (r_state == StEmit2 && w_xfer) begin
            w_valid_next = 1'b1;
            w_word_next  = r_word2;
            w_last_next  = 1'b1;
            w_state_next = StIdle;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_word  <= 32'd0;
            r_err   <= 1'b0;
`ifdef RV32I_ENCODE_LI_EXPAND_EN
            r_state <= StIdle;
            r_last  <= 1'b0;
            r_word2 <= 32'd0;
`endif
        end else begin
            r_valid <= w_valid_next;
            r_word  <= w_word_next;
            r_err   <= w_err_next;
`ifdef RV32I_ENCODE_LI_EXPAND_EN
            r_state <= w_state_next;
            r_last  <= w_last_next;
            r_word2 <= w_word2_next;
`endif
        end
    end

    assign inst_valid_o = r_valid;
    assign inst_word_o  = r_word;
    assign err_o        = r_err;

endmodule

// File: tb/tb_rv32i_encode.sv
// Directed bench for rv32i_encode; LI checks follow RV32I_ENCODE_LI_EXPAND_EN.
`timescale 1ns/1ps

module tb_rv32i_encode;

    logic        i_clk;
    logic        i_rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [4:0]  cmd_op_i;
    logic [4:0]  cmd_rd_i;
    logic [4:0]  cmd_rs1_i;
    logic [4:0]  cmd_rs2_i;
    logic [31:0] cmd_imm_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_word_o;
    logic        inst_last_o;
    logic        err_o;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        ok;
    } vec_t;

    vec_t vecs[18];

    rv32i_encode #(.N_param(32)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_rd_i     (cmd_rd_i),
        .cmd_rs1_i    (cmd_rs1_i),
        .cmd_rs2_i    (cmd_rs2_i),
        .cmd_imm_i    (cmd_imm_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_word_o  (inst_word_o),
        .inst_last_o  (inst_last_o),
        .err_o        (err_o)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Presents one command for exactly one clock edge; returns 1ns after that edge.
    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        cmd_op_i    = op;
        cmd_rd_i    = rd;
        cmd_rs1_i   = rs1;
        cmd_rs2_i   = rs2;
        cmd_imm_i   = imm;
        cmd_valid_i = 1'b1;
        @(posedge i_clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_last;
`ifdef RV32I_ENCODE_LI_EXPAND_EN
        exp_last = 1'b0;
`else
        exp_last = 1'b1;
`endif
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++;
        if (inst_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", inst_valid_o);
        else n_pass++;
        n_checks++;
        if (inst_word_o !== 32'd0) $display("FAIL rst_word: got %h want 00000000", inst_word_o);
        else n_pass++;
        n_checks++;
        if (inst_last_o !== exp_last) $display("FAIL rst_last: got %b want %b", inst_last_o, exp_last);
        else n_pass++;
        n_checks++;
        if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o);
        else n_pass++;
        n_checks++;
        if (cmd_ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", cmd_ready_o);
        else n_pass++;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_add();
        inst_ready_i = 1'b1;
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        n_checks++;
        if (inst_valid_o !== 1'b1) $display("FAIL add_valid: got %b want 1", inst_valid_o);
        else n_pass++;
        n_checks++;
        if (inst_word_o !== 32'h002081B3) $display("FAIL add_word: got %h want 002081b3", inst_word_o);
        else n_pass++;
        n_checks++;
        if (inst_last_o !== 1'b1) $display("FAIL add_last: got %b want 1", inst_last_o);
        else n_pass++;
        @(posedge i_clk);
        #1;
        n_checks++;
        if (inst_valid_o !== 1'b0) $display("FAIL add_drop: got %b want 0", inst_valid_o);
        else n_pass++;
    endtask

    task automatic test_reject();
        inst_ready_i = 1'b1;
        send(5'd10, 5'd5, 5'd0, 5'd0, 32'h0000_0800);
        n_checks++;
        if (err_o !== 1'b1) $display("FAIL rej_err: got %b want 1", err_o);
        else n_pass++;
        n_checks++;
        if (inst_valid_o !== 1'b0) $display("FAIL rej_valid: got %b want 0", inst_valid_o);
        else n_pass++;
        n_checks++;
        if (cmd_ready_o !== 1'b1) $display("FAIL rej_ready: got %b want 1", cmd_ready_o);
        else n_pass++;
        @(posedge i_clk);
        #1;
        n_checks++;
        if (err_o !== 1'b0) $display("FAIL rej_pulse: got %b want 0", err_o);
        else n_pass++;
    endtask

    task automatic test_vectors();
        vecs[0]  = '{5'd10, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00293, 1'b1}; // ADDI -1
        vecs[1]  = '{5'd10, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h80000093, 1'b1}; // ADDI -2048
        vecs[2]  = '{5'd18, 5'd1, 5'd2, 5'd0, 32'd3,         32'h40315093, 1'b1}; // SRAI
        vecs[3]  = '{5'd16, 5'd1, 5'd2, 5'd0, 32'd32,        32'd0,        1'b0}; // SLLI 32
        vecs[4]  = '{5'd22, 5'd0, 5'd1, 5'd2, 32'd8,         32'h00209463, 1'b1}; // BNE +8
        vecs[5]  = '{5'd21, 5'd0, 5'd0, 5'd0, 32'hFFFF_F000, 32'h80000063, 1'b1}; // BEQ -4096
        vecs[6]  = '{5'd21, 5'd0, 5'd1, 5'd2, 32'd3,         32'd0,        1'b0}; // BEQ odd
        vecs[7]  = '{5'd21, 5'd0, 5'd1, 5'd2, 32'd4096,      32'd0,        1'b0}; // BEQ range
        vecs[8]  = '{5'd23, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF, 1'b1}; // JAL
        vecs[9]  = '{5'd23, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'd0,        1'b0}; // JAL 1MiB
        vecs[10] = '{5'd25, 5'd5, 5'd0, 5'd0, 32'h000A_BCDE, 32'hABCDE2B7, 1'b1}; // LUI
        vecs[11] = '{5'd1,  5'd1, 5'd2, 5'd3, 32'd0,         32'h403100B3, 1'b1}; // SUB
        vecs[12] = '{5'd19, 5'd6, 5'd7, 5'd0, 32'hFFFF_FFFC, 32'hFFC3A303, 1'b1}; // LW -4
        vecs[13] = '{5'd24, 5'd1, 5'd5, 5'd0, 32'd0,         32'h000280E7, 1'b1}; // JALR
        vecs[14] = '{5'd28, 5'd0, 5'd0, 5'd0, 32'd0,         32'h00000013, 1'b1}; // NOP
        vecs[15] = '{5'd29, 5'd0, 5'd0, 5'd0, 32'd0,         32'h00000073, 1'b1}; // ECALL
        vecs[16] = '{5'd30, 5'd0, 5'd0, 5'd0, 32'd0,         32'h00100073, 1'b1}; // EBREAK
        vecs[17] = '{5'd31, 5'd0, 5'd0, 5'd0, 32'd0,         32'h30200073, 1'b1}; // MRET
        inst_ready_i = 1'b1;
        for (int i = 0; i < 18; i++) begin
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            n_checks++;
            if (inst_valid_o !== vecs[i].ok)
                $display("FAIL vec%0d_valid: got %b want %b", i, inst_valid_o, vecs[i].ok);
            else n_pass++;
            n_checks++;
            if (err_o !== !vecs[i].ok)
                $display("FAIL vec%0d_err: got %b want %b", i, err_o, !vecs[i].ok);
            else n_pass++;
            if (vecs[i].ok) begin
                n_checks++;
                if (inst_word_o !== vecs[i].word)
                    $display("FAIL vec%0d_word: got %h want %h", i, inst_word_o, vecs[i].word);
                else n_pass++;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_back_to_back();
        inst_ready_i = 1'b1;
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        n_checks++;
        if (inst_word_o !== 32'h002081B3) $display("FAIL b2b_w0: got %h want 002081b3", inst_word_o);
        else n_pass++;
        send(5'd5, 5'd4, 5'd5, 5'd6, 32'd0);
        n_checks++;
        if (inst_valid_o !== 1'b1) $display("FAIL b2b_valid: got %b want 1", inst_valid_o);
        else n_pass++;
        n_checks++;
        if (inst_word_o !== 32'h0062C233) $display("FAIL b2b_w1: got %h want 0062c233", inst_word_o);
        else n_pass++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_stall();
        inst_ready_i = 1'b0;
        send(5'd20, 5'd0, 5'd2, 5'd8, 32'd12);
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (inst_valid_o !== 1'b1 || inst_word_o !== 32'h00812623)
                $display("FAIL stall_hold%0d: got %b/%h want 1/00812623", c, inst_valid_o, inst_word_o);
            else n_pass++;
            n_checks++;
            if (cmd_ready_o !== 1'b0) $display("FAIL stall_ready%0d: got %b want 0", c, cmd_ready_o);
            else n_pass++;
            @(posedge i_clk);
            #1;
        end
        inst_ready_i = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1) $display("FAIL stall_rel_ready: got %b want 1", cmd_ready_o);
        else n_pass++;
        @(posedge i_clk);
        #1;
        n_checks++;
        if (inst_valid_o !== 1'b0) $display("FAIL stall_xfer: got %b want 0", inst_valid_o);
        else n_pass++;
    endtask

    task automatic test_li();
        inst_ready_i = 1'b1;
`ifdef RV32I_ENCODE_LI_EXPAND_EN
        send(5'd27, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
        n_checks++;
        if (inst_word_o !== 32'h12346537 || inst_last_o !== 1'b0)
            $display("FAIL li_w0: got %h/%b want 12346537/0", inst_word_o, inst_last_o);
        else n_pass++;
        n_checks++;
        if (cmd_ready_o !== 1'b0) $display("FAIL li_ready_mid: got %b want 0", cmd_ready_o);
        else n_pass++;
        @(posedge i_clk);
        #1;
        n_checks++;
        if (inst_valid_o !== 1'b1 || inst_word_o !== 32'hFFF50513 || inst_last_o !== 1'b1)
            $display("FAIL li_w1: got %b/%h/%b want 1/fff50513/1", inst_valid_o, inst_word_o,
                     inst_last_o);
        else n_pass++;
        @(posedge i_clk);
        #1;
        n_checks++;
        if (inst_valid_o !== 1'b0) $display("FAIL li_drop: got %b want 0", inst_valid_o);
        else n_pass++;
        send(5'd27, 5'd1, 5'd0, 5'd0, 32'h0000_1000);
        n_checks++;
        if (inst_word_o !== 32'h000010B7 || inst_last_o !== 1'b1)
            $display("FAIL li_lui_only: got %h/%b want 000010b7/1", inst_word_o, inst_last_o);
        else n_pass++;
        send(5'd27, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFB);
        n_checks++;
        if (inst_word_o !== 32'hFFB00113 || inst_last_o !== 1'b1)
            $display("FAIL li_addi_only: got %h/%b want ffb00113/1", inst_word_o, inst_last_o);
        else n_pass++;
`else
        send(5'd27, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
        n_checks++;
        if (err_o !== 1'b1 || inst_valid_o !== 1'b0)
            $display("FAIL li_reject: got err=%b valid=%b want err=1 valid=0", err_o, inst_valid_o);
        else n_pass++;
`endif
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset_mid();
        inst_ready_i = 1'b0;
`ifdef RV32I_ENCODE_LI_EXPAND_EN
        send(5'd27, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
`else
        send(5'd20, 5'd0, 5'd2, 5'd8, 32'd12);
`endif
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (inst_valid_o !== 1'b0) $display("FAIL midrst_valid: got %b want 0", inst_valid_o);
        else n_pass++;
        @(negedge i_clk);
        i_rst = 1'b0;
        inst_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk);
            #1;
            n_checks++;
            if (inst_valid_o !== 1'b0) $display("FAIL midrst_nowd%0d: got %b want 0", c, inst_valid_o);
            else n_pass++;
        end
        n_checks++;
        if (cmd_ready_o !== 1'b1) $display("FAIL midrst_ready: got %b want 1", cmd_ready_o);
        else n_pass++;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        i_rst        = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_op_i     = 5'd0;
        cmd_rd_i     = 5'd0;
        cmd_rs1_i    = 5'd0;
        cmd_rs2_i    = 5'd0;
        cmd_imm_i    = 32'd0;
        inst_ready_i = 1'b1;
        test_reset();
        test_add();
        test_reject();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_li();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
